// File: rtl/adc_capture_writer_pkg.sv
// Shared capture/render definitions: FSM encodings, default geometry, sample width.
package adc_capture_writer_pkg;
   localparam int SAMPLE_W   = 12;
   localparam int DEF_DEPTH  = 1280;
   localparam int DEF_ADDR_W = 12;

   localparam logic [1:0] ST_ARM       = 2'd0;
   localparam logic [1:0] ST_WAIT_TRIG = 2'd1;
   localparam logic [1:0] ST_FILL      = 2'd2;
   localparam logic [1:0] ST_FULL      = 2'd3;

   typedef logic signed [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/adc_trigger_detect.sv
// Signed rising-edge level trigger holding the previous sample.
// AUTO_TRIGGER_EN adds a WAIT_TRIG timeout that forces a trigger on flat input.
module adc_trigger_detect
   import adc_capture_writer_pkg::*;
#(
   parameter sample_t TRIG_LEVEL   = '0,
   parameter int      AUTO_TIMEOUT = 65535
) (
   input  logic    i_clk,
   input  logic    i_rst_n,
   input  sample_t i_sample,
   input  logic    i_valid,
   input  logic    i_arm,
   input  logic    i_wait,
   output logic    o_trig
);
   sample_t r_prev;
   logic    w_edge;

   assign w_edge = (r_prev < TRIG_LEVEL) && (i_sample >= TRIG_LEVEL);

`ifdef AUTO_TRIGGER_EN
   localparam int TO_W = $clog2(AUTO_TIMEOUT + 1);
   logic [TO_W-1:0] r_to_cnt;
   logic            w_timeout;

   // The strobe that would make the count reach AUTO_TIMEOUT is itself the trigger.
   assign w_timeout = (r_to_cnt == TO_W'(AUTO_TIMEOUT - 1));
   assign o_trig    = i_wait && i_valid && (w_edge || w_timeout);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_to_cnt <= '0;
      else if (!i_wait)
         r_to_cnt <= '0;
      else if (i_valid && !o_trig)
         r_to_cnt <= r_to_cnt + 1'b1;
   end
`else
   logic w_unused_timeout;
   assign w_unused_timeout = ^AUTO_TIMEOUT;
   assign o_trig = i_wait && i_valid && w_edge;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_prev <= '0;
      else if (i_valid && (i_arm || (i_wait && !o_trig)))
         r_prev <= i_sample;
   end
endmodule

// File: rtl/adc_capture_writer.sv
// Triggered ADC capture into the idle half of a ping-pong BRAM pair; swaps on frame sync.
// Optional AUTO_TRIGGER_EN macro enables the WAIT_TRIG auto-trigger timeout.
module adc_capture_writer
   import adc_capture_writer_pkg::*;
#(
   parameter int      DEPTH        = DEF_DEPTH,
   parameter int      ADDR_W       = DEF_ADDR_W,
   parameter sample_t TRIG_LEVEL   = 12'sd0,
   parameter int      AUTO_TIMEOUT = 65535
) (
   input  logic                CLK104MHZ,
   input  logic                CPU_RESETN,
   input  logic signed [11:0]  ADC_OUT,
   input  logic                ADC_VALID,
   input  logic                FRAME_SYNC,
   output logic                BRAM0_WE,
   output logic                BRAM1_WE,
   output logic [ADDR_W-1:0]   WR_ADDR,
   output logic [11:0]         WR_DATA,
   output logic                activeBRAMselect,
   output logic [1:0]          CAPTURE_STATE
);
   logic [1:0]        r_state;
   logic [ADDR_W-1:0] r_cnt;
   logic              r_sel;
   logic              r_we0;
   logic              r_we1;
   logic [ADDR_W-1:0] r_addr;
   logic [11:0]       r_data;

   logic              w_trig;
   logic              w_accept;
   logic [ADDR_W-1:0] w_wr_addr;
   logic              w_last;

   adc_trigger_detect #(
      .TRIG_LEVEL   (TRIG_LEVEL),
      .AUTO_TIMEOUT (AUTO_TIMEOUT)
   ) u_trig (
      .i_clk    (CLK104MHZ),
      .i_rst_n  (CPU_RESETN),
      .i_sample (ADC_OUT),
      .i_valid  (ADC_VALID),
      .i_arm    (r_state == ST_ARM),
      .i_wait   (r_state == ST_WAIT_TRIG),
      .o_trig   (w_trig)
   );

   // The trigger sample lands at address 0; FILL samples at the running count.
   assign w_accept  = (r_state == ST_WAIT_TRIG && w_trig) ||
                      (r_state == ST_FILL && ADC_VALID);
   assign w_wr_addr = (r_state == ST_FILL) ? r_cnt : '0;
   assign w_last    = (w_wr_addr == ADDR_W'(DEPTH - 1));

   always_ff @(posedge CLK104MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         r_state <= ST_ARM;
         r_cnt   <= '0;
         r_sel   <= 1'b0;
         r_we0   <= 1'b0;
         r_we1   <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
      end else begin
         r_we0 <= 1'b0;
         r_we1 <= 1'b0;
         if (w_accept) begin
            r_we0  <= r_sel;
            r_we1  <= ~r_sel;
            r_addr <= w_wr_addr;
            r_data <= ADC_OUT;
            if (w_last) begin
               r_state <= ST_FULL;
            end else begin
               r_cnt   <= w_wr_addr + 1'b1;
               r_state <= ST_FILL;
            end
         end else begin
            case (r_state)
               ST_ARM:
                  if (ADC_VALID) r_state <= ST_WAIT_TRIG;
               ST_FULL:
                  if (FRAME_SYNC) begin
                     r_sel   <= ~r_sel;
                     r_cnt   <= '0;
                     r_state <= ST_ARM;
                  end
               default: ;
            endcase
         end
      end
   end

   assign BRAM0_WE         = r_we0;
   assign BRAM1_WE         = r_we1;
   assign WR_ADDR          = r_addr;
   assign WR_DATA          = r_data;
   assign activeBRAMselect = r_sel;
   assign CAPTURE_STATE    = r_state;
endmodule

// File: tb/tb_adc_capture_writer.sv
// Directed bench for adc_capture_writer: trigger, full fill, swap, reset abort, flat input.
module tb_adc_capture_writer;
   logic               clk;
   logic               rst_n;
   logic signed [11:0] adc;
   logic               vld;
   logic               fsync;
   logic               we0;
   logic               we1;
   logic [11:0]        waddr;
   logic [11:0]        wdata;
   logic               sel;
   logic [1:0]         st;

   int n_chk  = 0;
   int n_fail = 0;

   adc_capture_writer #(
      .DEPTH        (1280),
      .ADDR_W       (12),
      .TRIG_LEVEL   (12'sd0),
      .AUTO_TIMEOUT (16)
   ) dut (
      .CLK104MHZ        (clk),
      .CPU_RESETN       (rst_n),
      .ADC_OUT          (adc),
      .ADC_VALID        (vld),
      .FRAME_SYNC       (fsync),
      .BRAM0_WE         (we0),
      .BRAM1_WE         (we1),
      .WR_ADDR          (waddr),
      .WR_DATA          (wdata),
      .activeBRAMselect (sel),
      .CAPTURE_STATE    (st)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: timeout reached, checks=%0d", n_chk);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle on the falling edge; outputs are checked 1 time unit after the rising edge.
   task automatic step(input logic v, input int d, input logic s);
      @(negedge clk);
      vld   = v;
      adc   = 12'(d);
      fsync = s;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_wr(input string tag, input logic e0, input logic e1,
                         input int a, input int d);
      logic [11:0] ed;
      ed = 12'(d);
      chk({tag, ".we0"}, 32'(we0), 32'(e0));
      chk({tag, ".we1"}, 32'(we1), 32'(e1));
      chk({tag, ".addr"}, 32'(waddr), 32'(a));
      chk({tag, ".data"}, 32'(wdata), 32'(ed));
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".no_we"}, 32'({we0, we1}), 32'd0);
   endtask

   int bad;

   initial begin
      rst_n = 1'b0; vld = 1'b0; adc = '0; fsync = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_wr("rst", 1'b0, 1'b0, 0, 0);
      chk("rst.sel", 32'(sel), 32'd0);
      chk("rst.state", 32'(st), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: ramp -5..0, crossing at sample 0
      for (int k = -5; k < 0; k++) begin
         step(1'b1, k, 1'b0);
         chk_idle("ramp");
      end
      chk("ramp.state", 32'(st), 32'd1);
      step(1'b1, 0, 1'b0);
      chk_wr("trig1", 1'b0, 1'b1, 0, 0);
      chk("trig1.state", 32'(st), 32'd2);

      // 2: back-to-back fill, data equals address
      bad = 0;
      for (int k = 1; k < 1280; k++) begin
         step(1'b1, k, 1'b0);
         if (we1 !== 1'b1 || we0 !== 1'b0 || waddr !== 12'(k) || wdata !== 12'(k)) bad++;
      end
      chk("fill1.bad_writes", 32'(bad), 32'd0);
      chk_wr("fill1.last", 1'b0, 1'b1, 1279, 1279);
      chk("fill1.state", 32'(st), 32'd3);
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 7, 1'b0);
         chk_idle("full");
      end
      chk("full.addr_hold", 32'(waddr), 32'd1279);
      chk("full.sel", 32'(sel), 32'd0);

      // 3: sync with a sample in the same cycle: swap, sample discarded
      step(1'b1, 50, 1'b1);
      chk_idle("swap");
      chk("swap.sel", 32'(sel), 32'd1);
      chk("swap.state", 32'(st), 32'd0);
      step(1'b1, -1, 1'b0);
      chk("arm2.state", 32'(st), 32'd1);
      step(1'b1, 5, 1'b1);
      chk_wr("trig2", 1'b1, 1'b0, 0, 5);
      chk("trig2.state", 32'(st), 32'd2);

      // 4: sync mid-fill is ignored
      bad = 0;
      for (int k = 1; k < 1280; k++) begin
         step(1'b1, k, (k == 600));
         if (we0 !== 1'b1 || we1 !== 1'b0 || waddr !== 12'(k) || sel !== 1'b1) bad++;
      end
      chk("fill2.bad_writes", 32'(bad), 32'd0);
      chk("fill2.state", 32'(st), 32'd3);
      chk("fill2.sel", 32'(sel), 32'd1);
      step(1'b0, 0, 1'b1);
      chk("swap2.sel", 32'(sel), 32'd0);

      // 5: async reset at address 300
      step(1'b1, -1, 1'b0);
      step(1'b1, 0, 1'b0);
      chk_wr("trig3", 1'b0, 1'b1, 0, 0);
      for (int k = 1; k <= 300; k++) step(1'b1, k, 1'b0);
      chk_wr("fill3.a300", 1'b0, 1'b1, 300, 300);
      #2;
      rst_n = 1'b0;
      #1;
      chk_wr("arst", 1'b0, 1'b0, 0, 0);
      chk("arst.state", 32'(st), 32'd0);
      @(negedge clk);
      vld = 1'b0;
      rst_n = 1'b1;
      step(1'b1, -3, 1'b0);
      step(1'b1, 2, 1'b0);
      chk_wr("trig4", 1'b0, 1'b1, 0, 2);
      chk("trig4.sel", 32'(sel), 32'd0);

      // 6: flat input below threshold
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, -100, 1'b0);
      for (int k = 1; k < 16; k++) step(1'b1, -100, 1'b0);
      chk("flat.15.state", 32'(st), 32'd1);
      step(1'b1, -100, 1'b0);
`ifdef AUTO_TRIGGER_EN
      chk_wr("flat.auto", 1'b0, 1'b1, 0, -100);
      chk("flat.auto.state", 32'(st), 32'd2);
`else
      chk_idle("flat.16");
      chk("flat.16.state", 32'(st), 32'd1);
      for (int k = 0; k < 20; k++) step(1'b1, -100, 1'b0);
      chk("flat.36.state", 32'(st), 32'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
